// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light reaction timer.
package f1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_REACT = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } f1_state_e;

  localparam logic [7:0] LIGHTS_ALL   = 8'hFF;
  localparam logic [7:0] LIGHTS_OFF   = 8'h00;
  localparam logic [7:0] LIGHTS_FAULT = 8'hAA;

  // x^7 + x^6 + 1: feedback from the two most significant stages
  localparam logic [6:0] LFSR_TAPS = 7'b110_0000;

  function automatic logic [6:0] lfsr_next(input logic [6:0] cur);
    return {cur[5:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/f1_lfsr.sv
// 7-bit Fibonacci LFSR used to randomise the lights-out delay.
module f1_lfsr
  import f1_pkg::*;
#(
  parameter logic [6:0] SEED = 7'h01
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] q
);

  logic [6:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= SEED;
    end else begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/f1_reaction_timer.sv
// F1 reaction timer: holds the full light bar for a random delay, then times the driver.
// Optional best-time tracking is enabled by defining F1_BEST_TIME_EN.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int         CNT_WIDTH = 16,
  parameter int         DELAY_MIN = 16,
  parameter logic [6:0] SEED      = 7'h01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [7:0]           lights_in,
  input  logic                 trigger,
  output logic                 seq_stall,
  output logic [7:0]           lights_out,
  output logic [CNT_WIDTH-1:0] react_time,
  output logic                 time_valid,
  output logic                 false_start,
  output logic [CNT_WIDTH-1:0] best_time
);

  localparam int DLY_W = $clog2(DELAY_MIN + 128);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  f1_state_e            state_q, state_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] rt_q, rt_d;
  logic                 valid_q, valid_d;
  logic                 fs_q;
  logic                 trig_q;
  logic                 press;
  logic [6:0]           lfsr;

  f1_lfsr #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign press = trigger & ~trig_q;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    cnt_d   = cnt_q;
    rt_d    = rt_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lights_in == LIGHTS_ALL) begin
          dly_d   = DLY_W'(DELAY_MIN) + DLY_W'(lfsr);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A press on the expiry tick is still a false start
        if (press) begin
          state_d = ST_FAULT;
        end else if (en) begin
          if (dly_q == DLY_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_REACT;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      ST_REACT: begin
        if (press) begin
          rt_d    = cnt_q;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          rt_d    = CNT_MAX;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else if (en) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_DONE, ST_FAULT: begin
        if (lights_in == LIGHTS_OFF) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      cnt_q   <= '0;
      rt_q    <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      rt_q    <= rt_d;
      valid_q <= valid_d;
      fs_q    <= (state_d == ST_FAULT);
      trig_q  <= trigger;
    end
  end

  always_comb begin
    case (state_q)
      ST_HOLD:           lights_out = LIGHTS_ALL;
      ST_REACT, ST_DONE: lights_out = LIGHTS_OFF;
      ST_FAULT:          lights_out = LIGHTS_FAULT;
      default:           lights_out = lights_in;
    endcase
  end

  // Stall in the very cycle the full bar is seen so the sequencer never runs ahead
  assign seq_stall = (state_q == ST_HOLD) || (state_q == ST_REACT) ||
                     ((state_q == ST_IDLE) && (lights_in == LIGHTS_ALL));

  assign react_time  = rt_q;
  assign time_valid  = valid_q;
  assign false_start = fs_q;

`ifdef F1_BEST_TIME_EN
  logic [CNT_WIDTH-1:0] best_q;
  logic                 scored;

  // Only genuine presses count; timeouts leave the record alone
  assign scored = (state_q == ST_REACT) && press;

  always_ff @(posedge clk) begin
    if (!rst) begin
      best_q <= '1;
    end else if (scored && (cnt_q < best_q)) begin
      best_q <= cnt_q;
    end
  end

  assign best_time = best_q;
`else
  assign best_time = '1;
`endif

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Self-checking bench: 16-bit and 4-bit timers run in lockstep from shared stimulus.
module tb_f1_reaction_timer;

  localparam int DELAY_MIN = 16;
  localparam logic [6:0] SEED = 7'h01;
  localparam int L = 512;

  logic clk = 1'b0;
  logic rst, en, trigger;
  logic [7:0] lights_in;

  logic        stall16, tv16, fs16, stall4, tv4, fs4;
  logic [7:0]  lo16, lo4;
  logic [15:0] rt16, best16;
  logic [3:0]  rt4, best4;

  always #5 clk = ~clk;

  f1_reaction_timer #(.CNT_WIDTH(16), .DELAY_MIN(DELAY_MIN), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .en(en), .lights_in(lights_in), .trigger(trigger),
    .seq_stall(stall16), .lights_out(lo16), .react_time(rt16), .time_valid(tv16),
    .false_start(fs16), .best_time(best16));

  f1_reaction_timer #(.CNT_WIDTH(4), .DELAY_MIN(DELAY_MIN), .SEED(SEED)) dut4 (
    .clk(clk), .rst(rst), .en(en), .lights_in(lights_in), .trigger(trigger),
    .seq_stall(stall4), .lights_out(lo4), .react_time(rt4), .time_valid(tv4),
    .false_start(fs4), .best_time(best4));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Clock edges seen with reset released = number of LFSR steps taken
  int lcnt = 0;
  always @(posedge clk) begin
    if (!rst) lcnt <= 0;
    else      lcnt <= lcnt + 1;
  end

  // Run description and reference results
  bit en_a[L];
  bit tr_a[L];
  int D, c_out, cp, lrun;
  bit flt;
  int ev[2], rtv[2];
  bit to[2];
  int exp_rt[2], exp_best[2];

  typedef struct {
    bit held;
    int hold_press;
    int react_press;
    int exp_rt16;
    int exp_rt4;
    int exp_best16;
    int exp_best4;
  } vec_t;
  vec_t tbl[8];

  function automatic int maxv(input int w);
    return (w == 0) ? 65535 : 15;
  endfunction

  function automatic int lfsr_at(input int k);
    logic [6:0] s;
    s = SEED;
    for (int i = 0; i < k; i++) s = {s[5:0], s[6] ^ s[5]};
    return int'(s);
  endfunction

  function automatic int best_exp(input int w);
`ifdef F1_BEST_TIME_EN
    return exp_best[w];
`else
    return maxv(w);
`endif
  endfunction

  function automatic int find_cout();
    int acc;
    acc = 0;
    for (int c = 0; c < L; c++) begin
      if (en_a[c]) begin
        acc++;
        if (acc == D) return c;
      end
    end
    return -1;
  endfunction

  function automatic int get_lo(input int w);   return (w == 0) ? int'(lo16) : int'(lo4); endfunction
  function automatic int get_st(input int w);   return (w == 0) ? int'(stall16) : int'(stall4); endfunction
  function automatic int get_tv(input int w);   return (w == 0) ? int'(tv16) : int'(tv4); endfunction
  function automatic int get_fs(input int w);   return (w == 0) ? int'(fs16) : int'(fs4); endfunction
  function automatic int get_rt(input int w);   return (w == 0) ? int'(rt16) : int'(rt4); endfunction
  function automatic int get_best(input int w); return (w == 0) ? int'(best16) : int'(best4); endfunction

  task automatic build_tr(input bit held);
    for (int c = 0; c < L; c++) tr_a[c] = (c >= cp) || (held && (c < cp - 1));
  endtask

  // Outcome from the rules: lights out after D en ticks; first button edge at or
  // before that tick is a false start; otherwise time = en ticks since lights out,
  // with a timeout once the count has reached all-ones.
  task automatic model(input bit held);
    int cnt;
    bit p;
    cp = -1;
    p = held;
    for (int c = 0; c < L; c++) begin
      if (tr_a[c] && !p && cp < 0) cp = c;
      p = tr_a[c];
    end
    c_out = find_cout();
    flt = (cp >= 0) && (cp <= c_out);
    for (int w = 0; w < 2; w++) begin
      ev[w] = L - 2;
      rtv[w] = exp_rt[w];
      to[w] = 1'b0;
      if (flt) begin
        ev[w] = cp;
      end else begin
        cnt = 0;
        for (int t = c_out + 1; t < L; t++) begin
          if (t == cp) begin
            ev[w] = t; rtv[w] = cnt; break;
          end
          if (cnt == maxv(w)) begin
            ev[w] = t; rtv[w] = cnt; to[w] = 1'b1; break;
          end
          if (en_a[t]) cnt++;
        end
      end
    end
    lrun = ((ev[0] > ev[1]) ? ev[0] : ev[1]) + 2;
    if (lrun > L) lrun = L;
  endtask

  function automatic int phase(input int w, input int c);
    if (flt) return (c <= cp) ? 0 : 3;
    if (c <= c_out) return 0;
    if (c <= ev[w]) return 1;
    return 2;
  endfunction

  task automatic exec_run(input int id, input bit held, input bit chk17);
    int hold_seen;
    int ph;
    int exp_lo;
    lights_in = 8'hFF; en = 1'b1; trigger = held;
    #1;
    chk($sformatf("r%0d detect_stall16", id), int'(stall16), 1);
    chk($sformatf("r%0d detect_stall4", id), int'(stall4), 1);
    chk($sformatf("r%0d detect_lo", id), int'(lo16), 255);
    @(posedge clk); #1;
    hold_seen = 0;
    for (int c = 0; c < lrun; c++) begin
      en = en_a[c]; trigger = tr_a[c];
      #1;
      if (lo16 == 8'hFF) hold_seen++;
      for (int w = 0; w < 2; w++) begin
        ph = phase(w, c);
        exp_lo = (ph == 0) ? 255 : (ph == 3) ? 170 : 0;
        chk($sformatf("r%0d c%0d w%0d lights_out", id, c, w), get_lo(w), exp_lo);
        chk($sformatf("r%0d c%0d w%0d seq_stall", id, c, w), get_st(w), int'(ph <= 1));
      end
      @(posedge clk); #1;
      for (int w = 0; w < 2; w++) begin
        chk($sformatf("r%0d c%0d w%0d time_valid", id, c, w), get_tv(w), int'(!flt && c == ev[w]));
        chk($sformatf("r%0d c%0d w%0d false_start", id, c, w), get_fs(w), int'(flt && c >= cp));
      end
    end
    for (int w = 0; w < 2; w++) begin
      if (!flt) begin
        exp_rt[w] = rtv[w];
        if (!to[w] && rtv[w] < exp_best[w]) exp_best[w] = rtv[w];
      end
      chk($sformatf("r%0d w%0d react_time", id, w), get_rt(w), exp_rt[w]);
      chk($sformatf("r%0d w%0d best_time", id, w), get_best(w), best_exp(w));
    end
    if (chk17) chk($sformatf("r%0d hold_ticks", id), hold_seen, 17);
    // Sequencer clears the bar, then starts a fresh pattern
    lights_in = 8'h00; trigger = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("r%0d fs16_cleared", id), int'(fs16), 0);
    chk($sformatf("r%0d fs4_cleared", id), int'(fs4), 0);
    lights_in = 8'h07;
    #1;
    chk($sformatf("r%0d idle_lo16", id), int'(lo16), 7);
    chk($sformatf("r%0d idle_lo4", id), int'(lo4), 7);
    chk($sformatf("r%0d idle_stall", id), int'(stall16), 0);
    @(posedge clk); #1;
  endtask

  task automatic directed(input int id, input vec_t v, input bit chk17);
    D = DELAY_MIN + lfsr_at(lcnt);
    for (int c = 0; c < L; c++) en_a[c] = 1'b1;
    c_out = D - 1;
    cp = (v.hold_press >= 0) ? v.hold_press : c_out + 1 + v.react_press;
    build_tr(v.held);
    model(v.held);
    exec_run(id, v.held, chk17);
  endtask

  task automatic do_reset(input bit chk_vals);
    rst = 1'b0; lights_in = 8'h3C; en = 1'b1; trigger = 1'b1;
    @(posedge clk); #1;
    exp_rt[0] = 0; exp_rt[1] = 0;
    exp_best[0] = maxv(0); exp_best[1] = maxv(1);
    if (chk_vals) begin
      chk("rst lights_out16", int'(lo16), 60);
      chk("rst lights_out4", int'(lo4), 60);
      chk("rst seq_stall", int'(stall16), 0);
      chk("rst react_time16", int'(rt16), 0);
      chk("rst react_time4", int'(rt4), 0);
      chk("rst time_valid16", int'(tv16), 0);
      chk("rst time_valid4", int'(tv4), 0);
      chk("rst false_start16", int'(fs16), 0);
      chk("rst best16", int'(best16), 65535);
      chk("rst best4", int'(best4), 15);
    end
    rst = 1'b1; trigger = 1'b0;
  endtask

  initial begin
    vec_t v;
    int mode;
    bit held;
    tbl[0] = '{1'b0, -1, 30, 30, 15, 30, 15};
    tbl[1] = '{1'b0, -1, 12, 12, 12, 12, 12};
    tbl[2] = '{1'b0, -1, 20, 20, 15, 12, 12};
    tbl[3] = '{1'b0,  5,  0, 20, 15, 12, 12};
    tbl[4] = '{1'b1, -1, 25, 25, 15, 12, 12};
    tbl[5] = '{1'b0, -1, -1, 25, 15, 12, 12};
    tbl[6] = '{1'b0, -1,  0,  0,  0,  0,  0};
    tbl[7] = '{1'b0, -1, 15, 15, 15,  0,  0};

    rst = 1'b0; en = 1'b0; trigger = 1'b0; lights_in = 8'h00;
    @(posedge clk); #1;
    do_reset(1'b1);

    for (int i = 0; i < 8; i++) begin
      directed(i, tbl[i], i == 0);
      chk($sformatf("tbl%0d react_time16", i), int'(rt16), tbl[i].exp_rt16);
      chk($sformatf("tbl%0d react_time4", i), int'(rt4), tbl[i].exp_rt4);
`ifdef F1_BEST_TIME_EN
      chk($sformatf("tbl%0d best16", i), int'(best16), tbl[i].exp_best16);
      chk($sformatf("tbl%0d best4", i), int'(best4), tbl[i].exp_best4);
`endif
    end

    // Reset at REACT tick 10 with a press pending: must abort silently
    D = DELAY_MIN + lfsr_at(lcnt);
    lights_in = 8'hFF; en = 1'b1; trigger = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < D + 10; c++) begin
      @(posedge clk); #1;
    end
    chk("midrst in_react", int'(lo16), 0);
    do_reset(1'b0);
    lights_in = 8'h00;
    #1;
    chk("midrst lights_out", int'(lo16), 0);
    chk("midrst seq_stall", int'(stall16), 0);
    chk("midrst react_time", int'(rt16), 0);
    chk("midrst time_valid", int'(tv16), 0);
    chk("midrst false_start", int'(fs16), 0);
    chk("midrst best16", int'(best16), 65535);
    v = '{1'b0, -1, 7, 7, 7, 7, 7};
    directed(100, v, 1'b1);
    chk("post_rst react_time4", int'(rt4), 7);

    for (int r = 0; r < 20; r++) begin
      D = DELAY_MIN + lfsr_at(lcnt);
      for (int c = 0; c < L; c++) en_a[c] = (c >= 300) || ($urandom_range(99) < 70);
      c_out = find_cout();
      mode = $urandom_range(3);
      held = (mode != 0) && ($urandom_range(1) == 1);
      if (mode == 0) cp = $urandom_range(c_out);
      else           cp = c_out + 1 + $urandom_range(40);
      build_tr(held);
      model(held);
      exec_run(200 + r, held, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
